// File: rtl/cim_rio_responder_if.sv
// cim_rio_responder_if: core-side bus of the CIM read-IO responder.
// master = AES core / bench side, slave = responder.
// CIM_RIO_PARITY_EN adds the tbl_wpar_flip fault-injection input.
interface cim_rio_responder_if #(
  parameter int ROUNDS  = 10,
  parameter int DEMUX_W = 3,
  parameter int RWL_W   = 6
);
  localparam int KW = $clog2(ROUNDS + 1);
  localparam int AW = DEMUX_W + RWL_W;

  logic                   start;
  logic [15:0]            IN;
  logic [16*DEMUX_W-1:0]  DEMUX_ADD;
  logic [16*RWL_W-1:0]    RWL_DEC_ADD;
  logic                   key_we;
  logic [KW-1:0]          key_waddr;
  logic [127:0]           key_wdata;
  logic                   tbl_we;
  logic [AW-1:0]          tbl_waddr;
  logic [7:0]             tbl_wdata;
`ifdef CIM_RIO_PARITY_EN
  logic                   tbl_wpar_flip;
`endif
  logic [127:0]           RIO;
  logic                   rio_vld;
  logic [1:0]             phase;
  logic [KW-1:0]          round_idx;
  logic                   busy;
  logic                   done;
  logic                   err;

  modport master (
    output start, IN, DEMUX_ADD, RWL_DEC_ADD,
    output key_we, key_waddr, key_wdata,
    output tbl_we, tbl_waddr, tbl_wdata,
`ifdef CIM_RIO_PARITY_EN
    output tbl_wpar_flip,
`endif
    input  RIO, rio_vld, phase, round_idx, busy, done, err
  );

  modport slave (
    input  start, IN, DEMUX_ADD, RWL_DEC_ADD,
    input  key_we, key_waddr, key_wdata,
    input  tbl_we, tbl_waddr, tbl_wdata,
`ifdef CIM_RIO_PARITY_EN
    input  tbl_wpar_flip,
`endif
    output RIO, rio_vld, phase, round_idx, busy, done, err
  );
endinterface

// File: rtl/cim_rio_responder.sv
// cim_rio_responder: CIM macro read-IO model for the bit-serial AES core.
// Per round: BS_CYCLES cycles of transposed AddRoundKey bits on the 16 RIO
// lanes, then one per-lane table lookup returned LOOKUP_LAT edges after the
// address capture. Optional macro CIM_RIO_PARITY_EN adds per-entry even
// parity with a sticky err flag.
module cim_rio_responder #(
  parameter int BS_CYCLES  = 8,
  parameter int LOOKUP_LAT = 1,
  parameter int ROUNDS     = 10,
  parameter int DEMUX_W    = 3,
  parameter int RWL_W      = 6
) (
  input  logic                CLK,
  input  logic                RSTn,
  cim_rio_responder_if.slave  bus
);
  localparam int KW    = $clog2(ROUNDS + 1);
  localparam int AW    = DEMUX_W + RWL_W;
  localparam int DEPTH = 1 << AW;
  localparam int LW    = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;
`ifdef CIM_RIO_PARITY_EN
  localparam int EW    = 9;
`else
  localparam int EW    = 8;
`endif

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARK = 2'd1, S_LOOK = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              bs_q;
  logic [LW-1:0]           lk_q;
  logic [KW-1:0]           rnd_q;
  logic [15:0][AW-1:0]     addr_q;
  logic [15:0][7:0]        rio_q;
  logic                    vld_q;
  logic                    done_q;

  logic [127:0]            key_mem [ROUNDS+1];
  logic [EW-1:0]           tbl_mem [DEPTH];

  logic [127:0]            cur_key;
  logic [15:0][7:0]        ark_d;
  logic [15:0][AW-1:0]     lane_addr;
  logic [15:0][7:0]        lk_data;
  logic                    ark_last;
  logic                    look_last;

  assign ark_last  = (state_q == S_ARK)  && (bs_q == 4'(BS_CYCLES - 1));
  assign look_last = (state_q == S_LOOK) && (lk_q == LW'(LOOKUP_LAT - 1));
  assign cur_key   = key_mem[rnd_q];

  // Memory writes: only in IDLE, so a run never sees its store change.
  // A write in the start cycle lands before the first ARK read.
  always_ff @(posedge CLK) begin
    if (bus.key_we && state_q == S_IDLE && 32'(bus.key_waddr) <= ROUNDS)
      key_mem[bus.key_waddr] <= bus.key_wdata;
    if (bus.tbl_we && state_q == S_IDLE)
`ifdef CIM_RIO_PARITY_EN
      tbl_mem[bus.tbl_waddr] <= {(^bus.tbl_wdata) ^ bus.tbl_wpar_flip, bus.tbl_wdata};
`else
      tbl_mem[bus.tbl_waddr] <= bus.tbl_wdata;
`endif
  end

  // Transpose the round key: lane 2i/2i+1 carry bit i of the even/odd key
  // bytes, lowest byte index in the lane MSB, masked by IN[i+8] / IN[i].
  always_comb begin
    ark_d = '0;
    for (int i = 0; i < 8; i++) begin
      for (int b = 0; b < 8; b++) begin
        ark_d[2*i][7-b]   = cur_key[120 - 16*b + i] ^ bus.IN[i+8];
        ark_d[2*i+1][7-b] = cur_key[112 - 16*b + i] ^ bus.IN[i];
      end
    end
  end

  // Unpack lane addresses and read the table at the captured addresses.
  always_comb begin
    lane_addr = '0;
    lk_data   = '0;
    for (int l = 0; l < 16; l++) begin
      lane_addr[l] = {bus.DEMUX_ADD[l*DEMUX_W +: DEMUX_W], bus.RWL_DEC_ADD[l*RWL_W +: RWL_W]};
      lk_data[l]   = tbl_mem[addr_q[l]][7:0];
    end
  end

  // Next-state: ARK bursts alternate with LOOK until the final key is used.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_ARK;
      S_ARK:   if (ark_last) state_d = (rnd_q < KW'(ROUNDS)) ? S_LOOK : S_IDLE;
      S_LOOK:  if (look_last) state_d = S_ARK;
      default: state_d = S_IDLE;
    endcase
  end

  // State register and datapath. Addresses are captured on the edge that
  // enters LOOK; the table data lands on the last LOOK edge, which is
  // LOOKUP_LAT edges later. Reset drops any lookup in flight.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      bs_q    <= '0;
      lk_q    <= '0;
      rnd_q   <= '0;
      addr_q  <= '0;
      rio_q   <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            bs_q  <= '0;
            lk_q  <= '0;
            rnd_q <= '0;
          end
        end
        S_ARK: begin
          rio_q <= ark_d;
          vld_q <= 1'b1;
          if (ark_last) begin
            bs_q <= '0;
            lk_q <= '0;
            if (rnd_q < KW'(ROUNDS)) addr_q <= lane_addr;
            else                     done_q <= 1'b1;
          end else begin
            bs_q <= bs_q + 4'd1;
          end
        end
        S_LOOK: begin
          if (look_last) begin
            rio_q <= lk_data;
            vld_q <= 1'b1;
            rnd_q <= rnd_q + KW'(1);
          end else begin
            lk_q <= lk_q + LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CIM_RIO_PARITY_EN
  logic [15:0] par_bad;
  logic        err_q;

  // Parity check per lane: stored bit makes the 9-bit entry even.
  always_comb begin
    par_bad = '0;
    for (int l = 0; l < 16; l++) par_bad[l] = ^tbl_mem[addr_q[l]];
  end

  // Sticky error, cleared by reset or the next accepted start.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)                                err_q <= 1'b0;
    else if (state_q == S_IDLE && bus.start)  err_q <= 1'b0;
    else if (look_last && (|par_bad))         err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.RIO       = rio_q;
  assign bus.rio_vld   = vld_q;
  assign bus.phase     = state_q;
  assign bus.round_idx = rnd_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
endmodule

// File: tb/tb_cim_rio_responder.sv
// tb_cim_rio_responder: directed bench for cim_rio_responder.
// u_dut runs defaults; u_dut3 uses LOOKUP_LAT=3 and mirrors u_dut's inputs
// except start.
module tb_cim_rio_responder;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  cim_rio_responder_if b ();
  cim_rio_responder_if b3 ();

  cim_rio_responder u_dut (.CLK(clk), .RSTn(rstn), .bus(b));
  cim_rio_responder #(.LOOKUP_LAT(3)) u_dut3 (.CLK(clk), .RSTn(rstn), .bus(b3));

  assign b3.IN          = b.IN;
  assign b3.DEMUX_ADD   = b.DEMUX_ADD;
  assign b3.RWL_DEC_ADD = b.RWL_DEC_ADD;
  assign b3.key_we      = b.key_we;
  assign b3.key_waddr   = b.key_waddr;
  assign b3.key_wdata   = b.key_wdata;
  assign b3.tbl_we      = b.tbl_we;
  assign b3.tbl_waddr   = b.tbl_waddr;
  assign b3.tbl_wdata   = b.tbl_wdata;
`ifdef CIM_RIO_PARITY_EN
  assign b3.tbl_wpar_flip = b.tbl_wpar_flip;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic [127:0] keys [11];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference transposition: lane L, lane bit 7-j = bit (L/2) of key byte
  // 2j+(L%2), masked by IN[L/2] for odd lanes and IN[L/2+8] for even lanes.
  function automatic logic [127:0] ark_model(input logic [127:0] k, input logic [15:0] m);
    logic [127:0] r;
    logic [7:0]   kb;
    int           n;
    int           bp;
    logic         mb;
    r = '0;
    for (int L = 0; L < 16; L++) begin
      for (int j = 0; j < 8; j++) begin
        n  = 2*j + (L % 2);
        bp = L / 2;
        kb = k[127-8*n -: 8];
        mb = (L % 2 == 1) ? m[bp] : m[bp+8];
        r[8*L + 7 - j] = kb[bp] ^ mb;
      end
    end
    return r;
  endfunction

  // FIPS-197 AES-128 key schedule into keys[0..10].
  task automatic expand_key(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [79:0] rc;
    rc = 80'h01020408102040801b36;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]};
        t[31:24] = t[31:24] ^ rc[79-8*(i/4-1) -: 8];
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic wr_key(input int a, input logic [127:0] d);
    b.key_we = 1'b1; b.key_waddr = a[3:0]; b.key_wdata = d;
    tick;
    b.key_we = 1'b0;
  endtask

  task automatic wr_tbl(input int a, input logic [7:0] d, input logic flip);
    b.tbl_we = 1'b1; b.tbl_waddr = a[8:0]; b.tbl_wdata = d;
`ifdef CIM_RIO_PARITY_EN
    b.tbl_wpar_flip = flip;
`endif
    tick;
    b.tbl_we = 1'b0;
`ifdef CIM_RIO_PARITY_EN
    b.tbl_wpar_flip = 1'b0;
`endif
  endtask

  task automatic set_addr(input int l, input logic [8:0] a);
    b.DEMUX_ADD[l*3 +: 3]   = a[8:6];
    b.RWL_DEC_ADD[l*6 +: 6] = a[5:0];
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (b.done !== 1'b1 && n < bound) begin tick; n++; end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    b.start = 1'b0; b3.start = 1'b0; b.IN = '0; b.DEMUX_ADD = '0; b.RWL_DEC_ADD = '0;
    b.key_we = 1'b0; b.key_waddr = '0; b.key_wdata = '0;
    b.tbl_we = 1'b0; b.tbl_waddr = '0; b.tbl_wdata = '0;
`ifdef CIM_RIO_PARITY_EN
    b.tbl_wpar_flip = 1'b0;
`endif
    tick; tick;
    checks++; if (b.RIO !== 128'h0) begin errors++; $display("FAIL reset_rio: got %h want 0", b.RIO); end
    checks++; if ({b.rio_vld, b.busy, b.done, b.err} !== 4'b0) begin errors++;
      $display("FAIL reset_flags: got vld/busy/done/err %b want 0000", {b.rio_vld, b.busy, b.done, b.err}); end
    checks++; if ({b.phase, b.round_idx} !== 6'h0) begin errors++;
      $display("FAIL reset_phase_round: got %h/%h want 0/0", b.phase, b.round_idx); end
    rstn = 1'b1;
    tick;
  endtask

  task automatic test_ark;
    int n;
    wr_key(0, 128'h000102030405060708090a0b0c0d0e0f);
    b.IN = 16'h0; b.start = 1'b1;
    tick;
    b.start = 1'b0;
    checks++; if ({b.busy, b.phase, b.rio_vld} !== 4'b1010) begin errors++;
      $display("FAIL start_accept: got busy/phase/vld %b/%0d/%b want 1/1/0", b.busy, b.phase, b.rio_vld); end
    tick;
    checks++; if (b.rio_vld !== 1'b1) begin errors++; $display("FAIL ark_vld: got %b want 1", b.rio_vld); end
    checks++; if (b.RIO[23:0] !== 24'h55ff00) begin errors++;
      $display("FAIL ark_lanes012: got %h want 55ff00", b.RIO[23:0]); end
    b.IN = 16'h0001;
    tick;
    checks++; if (b.RIO[15:0] !== 16'h0000) begin errors++;
      $display("FAIL ark_in_mask: got %h want 0000", b.RIO[15:0]); end
    b.IN = 16'h0;
    // done lands 98 edges after the start edge; two edges already consumed
    wait_done(200, n);
    checks++; if (n !== 96) begin errors++; $display("FAIL ark_run_len: got %0d want 96", n); end
    tick;
  endtask

  task automatic load_fips;
    expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    for (int r = 0; r < 11; r++) wr_key(r, keys[r]);
    for (int a = 0; a < 256; a++) wr_tbl(a, SBOX[a], 1'b0);
  endtask

  task automatic test_lookup_latency;
    int n;
    for (int l = 0; l < 16; l++) set_addr(l, 9'h053);
    b3.start = 1'b1;
    tick;
    b3.start = 1'b0;
    n = 1;
    while (b3.phase !== 2'd2 && n < 30) begin tick; n++; end
    checks++; if (n !== 9 || b3.rio_vld !== 1'b1) begin errors++;
      $display("FAIL lat_enter_look: got edge %0d vld %b want 9/1", n, b3.rio_vld); end
    tick;
    checks++; if (b3.rio_vld !== 1'b0) begin errors++; $display("FAIL lat_gap1: got vld %b want 0", b3.rio_vld); end
    tick;
    checks++; if (b3.rio_vld !== 1'b0) begin errors++; $display("FAIL lat_gap2: got vld %b want 0", b3.rio_vld); end
    tick;
    checks++; if (b3.rio_vld !== 1'b1 || b3.RIO !== {16{8'hED}}) begin errors++;
      $display("FAIL lat_data: got vld %b rio %h want 1/%h", b3.rio_vld, b3.RIO, {16{8'hED}}); end
    n = 0;
    while (b3.done !== 1'b1 && n < 200) begin tick; n++; end
    checks++; if (n !== 107) begin errors++; $display("FAIL lat_run_len: got %0d want 107", n); end
    tick;
  endtask

  task automatic test_full_run;
    logic [1:0]   pph;
    logic [3:0]   prn;
    logic [15:0]  in_v;
    logic [127:0] exp_lk;
    logic [8:0]   a;
    int           arkc [11];
    int           lookc;
    int           dcyc;
    for (int l = 0; l < 16; l++) begin
      a = 9'(l * 17);
      set_addr(l, a);
      exp_lk[8*l +: 8] = SBOX[l * 17];
    end
    for (int r = 0; r < 11; r++) arkc[r] = 0;
    lookc = 0; dcyc = 0;
    b.start = 1'b1;
    tick;
    b.start = 1'b0;
    pph = b.phase; prn = b.round_idx;
    for (int c = 1; c <= 150; c++) begin
      in_v = {c[7:0], ~c[7:0]};
      b.IN = in_v;
      tick;
      if (pph == 2'd1) begin
        arkc[prn]++;
        checks++; if (b.rio_vld !== 1'b1 || b.RIO !== ark_model(keys[prn], in_v)) begin errors++;
          $display("FAIL full_ark r%0d c%0d: got vld %b rio %h want 1/%h", prn, c, b.rio_vld, b.RIO, ark_model(keys[prn], in_v)); end
      end else if (pph == 2'd2 && b.rio_vld === 1'b1) begin
        lookc++;
        checks++; if (b.RIO !== exp_lk) begin errors++;
          $display("FAIL full_lookup c%0d: got %h want %h", c, b.RIO, exp_lk); end
      end
      if (b.round_idx !== prn) begin
        checks++; if (b.round_idx !== prn + 4'd1) begin errors++;
          $display("FAIL full_round_step: got %0d want %0d", b.round_idx, prn + 4'd1); end
      end
      pph = b.phase; prn = b.round_idx;
      if (b.done === 1'b1) begin dcyc = c; break; end
    end
    b.IN = '0;
    checks++; if (dcyc !== 98) begin errors++; $display("FAIL full_done_cycle: got %0d want 98", dcyc); end
    checks++; if (lookc !== 10) begin errors++; $display("FAIL full_lookups: got %0d want 10", lookc); end
    checks++; if (prn !== 4'd10 || b.busy !== 1'b0) begin errors++;
      $display("FAIL full_end_state: got round %0d busy %b want 10/0", prn, b.busy); end
    checks++; if (b.err !== 1'b0) begin errors++; $display("FAIL full_err: got %b want 0", b.err); end
    for (int r = 0; r < 11; r++) begin
      checks++; if (arkc[r] !== 8) begin errors++; $display("FAIL full_ark_burst r%0d: got %0d want 8", r, arkc[r]); end
    end
    tick;
  endtask

  task automatic test_protocol;
    int m;
    b.IN = '0; b.start = 1'b1;
    tick;
    b.start = 1'b0;
    repeat (20) tick;
    b.start = 1'b1;
    b.key_we = 1'b1; b.key_waddr = 4'd0; b.key_wdata = ~keys[0];
    tick;
    b.start = 1'b0; b.key_we = 1'b0;
    // 21 edges used since the start edge; done due at edge 98
    wait_done(200, m);
    checks++; if (m !== 77) begin errors++; $display("FAIL proto_start_ignored: got %0d want 77", m); end
    b.start = 1'b1;
    tick;
    b.start = 1'b0;
    checks++; if ({b.busy, b.phase, b.round_idx, b.done} !== {1'b1, 2'd1, 4'd0, 1'b0}) begin errors++;
      $display("FAIL proto_done_restart: got busy/phase/round/done %b/%0d/%0d/%b want 1/1/0/0", b.busy, b.phase, b.round_idx, b.done); end
    b.IN = 16'h8001;
    tick;
    checks++; if (b.rio_vld !== 1'b1 || b.RIO !== ark_model(keys[0], 16'h8001)) begin errors++;
      $display("FAIL proto_key_kept: got %h want %h", b.RIO, ark_model(keys[0], 16'h8001)); end
    b.IN = '0;
  endtask

  task automatic test_reset_mid_look;
    int n;
    n = 0;
    while (b.phase !== 2'd2 && n < 20) begin tick; n++; end
    checks++; if (n !== 7) begin errors++; $display("FAIL rst_reach_look: got %0d want 7", n); end
    #1;
    rstn = 1'b0;
    #1;
    checks++; if (b.RIO !== 128'h0 || {b.rio_vld, b.busy, b.done, b.err} !== 4'b0) begin errors++;
      $display("FAIL rst_async_out: got rio %h flags %b want 0/0000", b.RIO, {b.rio_vld, b.busy, b.done, b.err}); end
    checks++; if ({b.phase, b.round_idx} !== 6'h0) begin errors++;
      $display("FAIL rst_async_state: got %0d/%0d want 0/0", b.phase, b.round_idx); end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++; if (b.rio_vld !== 1'b0 || b.phase !== 2'd0) begin errors++;
        $display("FAIL rst_no_late_vld %0d: got vld %b phase %0d want 0/0", i, b.rio_vld, b.phase); end
    end
  endtask

`ifdef CIM_RIO_PARITY_EN
  task automatic test_parity;
    int n;
    wr_tbl(16'h10, 8'hA5, 1'b1);
    for (int l = 0; l < 16; l++) set_addr(l, 9'h010);
    b.start = 1'b1;
    tick;
    b.start = 1'b0;
    n = 0;
    while (b.phase !== 2'd2 && n < 20) begin tick; n++; end
    tick;
    checks++; if (b.err !== 1'b1 || b.RIO !== {16{8'hA5}}) begin errors++;
      $display("FAIL par_detect: got err %b rio %h want 1/%h", b.err, b.RIO, {16{8'hA5}}); end
    wait_done(200, n);
    checks++; if (b.err !== 1'b1) begin errors++; $display("FAIL par_sticky: got %b want 1", b.err); end
    b.start = 1'b1;
    tick;
    b.start = 1'b0;
    checks++; if (b.err !== 1'b0) begin errors++; $display("FAIL par_clear: got %b want 0", b.err); end
  endtask
`endif

  initial begin
    test_reset;
    test_ark;
    load_fips;
    test_lookup_latency;
    test_full_run;
    test_protocol;
    test_reset_mid_look;
`ifdef CIM_RIO_PARITY_EN
    test_parity;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cim_rio_responder.md
# cim_rio_responder

Synthesizable, parametrised model of the CIM macro read-IO (RIO) side that serves the bit-serial AES datapath. It stores the round keys and the substitution table. Per round it streams the transposed AddRoundKey bits onto the 16 RIO lanes for a configurable number of bit-serial cycles, then answers a per-lane table lookup after a programmable latency. It sits between the AES core (which issues `IN`, `DEMUX_ADD_xx`, `RWL_DEC_ADD_xx`) and the RIO return bus. It replaces the fixed-latency, hard-coded-key bench responder.

## Interface
- `BS_CYCLES`, 8: bit-serial ARK cycles per round (1..15).
- `LOOKUP_LAT`, 1: cycles from address sample to RIO lookup data (1..4).
- `ROUNDS`, 10: substitution rounds; key store holds `ROUNDS+1` keys.
- `DEMUX_W`, 3: DEMUX address width per lane.
- `RWL_W`, 6: RWL decoder address width per lane. Table depth is 2^(DEMUX_W+RWL_W).
- `CLK`  in  1  clock, rising edge.
- `RSTn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  run request; accepted only when `busy`=0.
- `IN`  in  16  per-cycle XOR mask from the core.
- `DEMUX_ADD`  in  16*DEMUX_W  packed lane addresses, lane 0 in LSBs.
- `RWL_DEC_ADD`  in  16*RWL_W  packed, lane 0 in LSBs.
- `key_we`, `key_waddr`, `key_wdata`  in  1, clog2(ROUNDS+1), 128  round-key write port.
- `tbl_we`, `tbl_waddr`, `tbl_wdata`  in  1, DEMUX_W+RWL_W, 8  table write port.
- `RIO`  out  128  lane L at [8L+7:8L].
- `rio_vld`  out  1  `RIO` updated this cycle.
- `phase`  out  2  0 IDLE, 1 ARK, 2 LOOK.
- `round_idx`  out  clog2(ROUNDS+1)  current key index.
- `busy`, `done`, `err`  out  1 each.

## Operation
- States: IDLE, ARK, LOOK.
- IDLE→ARK on `start`. `round_idx`=0 and the bit counter is cleared.
- ARK, each cycle:
  - `RIO[2i]` = {kb0[i],kb2[i],…,kb14[i]} ^ {8{IN[i+8]}}.
  - `RIO[2i+1]` = {kb1[i],kb3[i],…,kb15[i]} ^ {8{IN[i]}}, for i=0..7.
  - kbN is byte N of key[`round_idx`], with byte 0 at [127:120]. MSB of each lane is the lowest byte index.
  - `rio_vld`=1.
- After BS_CYCLES ARK cycles: if `round_idx`<ROUNDS go to LOOK; otherwise pulse `done` and go to IDLE.
- LOOK:
  - On the first cycle, every lane's address {DEMUX_ADD_L, RWL_DEC_ADD_L} is sampled.
  - `RIO[L]` = table[addr_L] with `rio_vld`=1, exactly LOOKUP_LAT edges later.
  - The state lasts LOOKUP_LAT cycles, then `round_idx`++ and the block returns to ARK.
- `start` while `busy` is ignored.
- `key_we` / `tbl_we` while `busy` are dropped. Memories are written in IDLE only.
- A key or table write to an address in the same cycle as `start` completes before the run reads it.
- Memories are not reset; their contents are undefined until written.
- Without `CIM_RIO_PARITY_EN`, `err` is tied 0.

## Timing
- Reset values: `RIO`=0, `rio_vld`=0, `phase`=0, `round_idx`=0, `busy`=0, `done`=0, `err`=0.
- Reset asserted mid-run returns the block to IDLE immediately. Any pending lookup data is discarded and `rio_vld` stays 0 after release.
- If `start` is accepted at edge t, `busy`=1 from t and the first ARK `RIO` appears at edge t+1.
- Run length = (ROUNDS+1)*BS_CYCLES + ROUNDS*LOOKUP_LAT cycles. Defaults: 98.
- `done` is a 1-cycle pulse coincident with `busy` falling. A new `start` is accepted in the same cycle `done` is high.
- `rio_vld` is 0 during LOOK cycles that carry no data, and in IDLE.
- `RIO` holds its last value when `rio_vld`=0.

## Configuration
- `CIM_RIO_PARITY_EN` defined:
  - Each table entry stores an even-parity bit, computed on write.
  - Extra input `tbl_wpar_flip` inverts the stored parity bit (fault-injection hook).
  - On each lookup, a parity mismatch on any lane sets `err`. `err` is sticky until the next accepted `start` or reset.
  - Lookup data is still returned unmodified.
- Undefined: no parity storage, no `tbl_wpar_flip` port, `err`=0.

## Test plan
- ARK transposition: key[0]=000102…0e0f, `IN`=0 → first ARK `RIO[0]`=00, `RIO[1]`=FF, `RIO[2]`=55. With `IN`=16'h0001 → `RIO[1]`=00.
- Lookup latency:
  - Setup: LOOKUP_LAT=3, table[0x053]=ED, all lanes address 9'h053.
  - Required: `RIO` all ED with `rio_vld`=1 exactly 3 edges after sampling, and `rio_vld`=0 on the two cycles before.
- Full AES run:
  - Setup: FIPS-197 keys, S-box in table[0..255], defaults.
  - Required: `done` 98 cycles after `start`; `round_idx` steps 0..10; 11 ARK bursts of 8 and 10 lookups.
- Protocol: `start` and `key_we` mid-run are ignored and key contents are unchanged; `start` in the `done` cycle is accepted.
- Reset mid-LOOK: `RSTn` low for 1 cycle → all outputs 0 at once, IDLE, no late `rio_vld`.
- Parity (macro on): write table[0x10] with `tbl_wpar_flip`=1, look it up → `err`=1 persisting; next `start` clears it.
